// File: rtl/fifo_stream_reader_if.sv
// Reader-side bundle: FIFO pop port plus narrow valid/ready beat stream.
// FIFO_READER_LAST_EN adds out_last (word boundary marker).
interface fifo_stream_reader_if #(
  parameter int W_IN  = 32,
  parameter int RATIO = 4
);
  localparam int W_OUT = W_IN / RATIO;

  logic [W_IN-1:0]  fifo_rdata;
  logic             fifo_empty;
  logic             fifo_ren;
  logic [W_OUT-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef FIFO_READER_LAST_EN
  logic             out_last;
`endif

  modport master (
    input  fifo_rdata,
    input  fifo_empty,
    input  out_ready,
    output fifo_ren,
    output out_data,
    output out_valid,
`ifdef FIFO_READER_LAST_EN
    output out_last,
`endif
    output busy
  );

  modport slave (
    output fifo_rdata,
    output fifo_empty,
    output out_ready,
    input  fifo_ren,
    input  out_data,
    input  out_valid,
`ifdef FIFO_READER_LAST_EN
    input  out_last,
`endif
    input  busy
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops W_IN-bit words from a show-ahead FIFO, emits RATIO LSB-first beats.
// FIFO_READER_LAST_EN enables out_last on the final beat of each word.
module fifo_stream_reader #(
  parameter int W_IN  = 32,
  parameter int RATIO = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
);
  localparam int W_OUT  = W_IN / RATIO;
  localparam int W_BEAT = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [W_BEAT-1:0] LAST_BEAT = W_BEAT'(RATIO - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [W_BEAT-1:0] beat_q, beat_d;
  logic [W_IN-1:0]   shreg_q, shreg_d;

  logic vld;
  logic acc;
  logic last;
  logic ren;

  assign vld  = (state_q == ACTIVE);
  assign acc  = vld && bus.out_ready;
  assign last = (beat_q == LAST_BEAT);
  // Refill on the final accepted beat so words stream without a bubble.
  assign ren  = !bus.fifo_empty && (!vld || (acc && last));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shreg_d = shreg_q;
    unique case (1'b1)
      ren: begin
        state_d = ACTIVE;
        beat_d  = '0;
        shreg_d = bus.fifo_rdata;
      end
      acc && !last: begin
        beat_d  = beat_q + W_BEAT'(1);
        shreg_d = shreg_q >> W_OUT;
      end
      acc && last && bus.fifo_empty: begin
        state_d = IDLE;
        beat_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Data path carries no reset; out_data is don't-care while idle.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign bus.fifo_ren  = ren;
  assign bus.out_data  = shreg_q[W_OUT-1:0];
  assign bus.out_valid = vld;
  assign bus.busy      = vld || !bus.fifo_empty;
`ifdef FIFO_READER_LAST_EN
  assign bus.out_last  = vld && last;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: 32->4x8 reader plus a RATIO=1 8-bit instance,
// each fed by a queue modelling a show-ahead FIFO.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.W_IN(32), .RATIO(4)) bus ();
  fifo_stream_reader_if #(.W_IN(8),  .RATIO(1)) bus8 ();

  fifo_stream_reader #(.W_IN(32), .RATIO(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fifo_stream_reader #(.W_IN(8), .RATIO(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  logic [31:0] q32[$];
  logic [7:0]  q8[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void upd();
    bus.fifo_empty  = (q32.size() == 0);
    bus.fifo_rdata  = (q32.size() == 0) ? 32'h0 : q32[0];
    bus8.fifo_empty = (q8.size() == 0);
    bus8.fifo_rdata = (q8.size() == 0) ? 8'h0 : q8[0];
  endfunction

  // Called just after a negedge; pops the model FIFOs on the next posedge.
  task automatic adv();
    logic p32, p8;
    p32 = bus.fifo_ren;
    p8  = bus8.fifo_ren;
    @(posedge clk);
    @(negedge clk);
    if (p32 && q32.size() != 0) void'(q32.pop_front());
    if (p8 && q8.size() != 0) void'(q8.pop_front());
    upd();
  endtask

  task automatic ex(input string tag, input logic r, input logic v,
                    input logic [7:0] d, input logic l);
    #1;
    chk({tag, "_ren"}, 32'(bus.fifo_ren), 32'(r));
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(v || q32.size() != 0));
    if (v) chk({tag, "_dat"}, 32'(bus.out_data), 32'(d));
`ifdef FIFO_READER_LAST_EN
    chk({tag, "_last"}, 32'(bus.out_last), 32'(l));
`else
    if (l && !v) chk({tag, "_lastv"}, 32'(l), 32'(v));
`endif
    adv();
  endtask

  task automatic ex8(input string tag, input logic r, input logic v,
                     input logic [7:0] d);
    #1;
    chk({tag, "_ren"}, 32'(bus8.fifo_ren), 32'(r));
    chk({tag, "_vld"}, 32'(bus8.out_valid), 32'(v));
    if (v) chk({tag, "_dat"}, 32'(bus8.out_data), 32'(d));
    adv();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.out_ready  = 1'b1;
    bus8.out_ready = 1'b0;
    upd();
    @(negedge clk);

    for (int i = 0; i < 5; i++) ex("t1_rst", 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) ex("t1_idle", 0, 0, 8'h00, 0);

    q32.push_back(32'hDDCCBBAA);
    upd();
    ex("t2_pop", 1, 0, 8'h00, 0);
    ex("t2_b0", 0, 1, 8'hAA, 0);
    ex("t2_b1", 0, 1, 8'hBB, 0);
    ex("t2_b2", 0, 1, 8'hCC, 0);
    ex("t2_b3", 0, 1, 8'hDD, 1);
    ex("t2_end", 0, 0, 8'h00, 0);

    q32.push_back(32'h44332211);
    q32.push_back(32'h88776655);
    upd();
    ex("t3_pop", 1, 0, 8'h00, 0);
    ex("t3_11", 0, 1, 8'h11, 0);
    ex("t3_22", 0, 1, 8'h22, 0);
    ex("t3_33", 0, 1, 8'h33, 0);
    ex("t3_44", 1, 1, 8'h44, 1);
    ex("t3_55", 0, 1, 8'h55, 0);
    ex("t3_66", 0, 1, 8'h66, 0);
    ex("t3_77", 0, 1, 8'h77, 0);
    ex("t3_88", 0, 1, 8'h88, 1);
    ex("t3_end", 0, 0, 8'h00, 0);

    q32.push_back(32'h04030201);
    upd();
    ex("t4_pop", 1, 0, 8'h00, 0);
    ex("t4_01", 0, 1, 8'h01, 0);
    bus.out_ready = 1'b0;
    ex("t4_hold1", 0, 1, 8'h02, 0);
    ex("t4_hold2", 0, 1, 8'h02, 0);
    bus.out_ready = 1'b1;
    ex("t4_02", 0, 1, 8'h02, 0);
    ex("t4_03", 0, 1, 8'h03, 0);
    ex("t4_04", 0, 1, 8'h04, 1);
    ex("t4_end", 0, 0, 8'h00, 0);

    q32.push_back(32'hDDCCBBAA);
    upd();
    ex("t5_pop", 1, 0, 8'h00, 0);
    ex("t5_aa", 0, 1, 8'hAA, 0);
    ex("t5_bb", 0, 1, 8'hBB, 0);
    rst_n = 1'b0;
    ex("t5_rst", 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    ex("t5_idle", 0, 0, 8'h00, 0);
    q32.push_back(32'h000000EE);
    upd();
    ex("t5_pop2", 1, 0, 8'h00, 0);
    ex("t5_ee", 0, 1, 8'hEE, 0);
    ex("t5_z1", 0, 1, 8'h00, 0);
    ex("t5_z2", 0, 1, 8'h00, 0);
    ex("t5_z3", 0, 1, 8'h00, 1);
    ex("t5_end", 0, 0, 8'h00, 0);

    q8.push_back(8'h5A);
    q8.push_back(8'hA5);
    upd();
    ex8("t6_pop", 1, 0, 8'h00);
    ex8("t6_hold1", 0, 1, 8'h5A);
    ex8("t6_hold2", 0, 1, 8'h5A);
    bus8.out_ready = 1'b1;
    ex8("t6_5a", 1, 1, 8'h5A);
    ex8("t6_a5", 0, 1, 8'hA5);
    ex8("t6_end", 0, 0, 8'h00);
    ex8("t6_idle", 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
